// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_arbiter
//   Arbitrates a single-port instruction memory between the CPU fetch port and
//   a loader port. One grant per cycle. The grant and the memory strobes are
//   combinational in the grant cycle. The read response follows one cycle
//   later on the requester that was granted.
//   The loader can take exclusive ownership with load_lock.
//   An access that is misaligned or out of range is still granted, but it
//   never reaches memory. A read of that kind returns a NOP (0x00000013), and
//   both reads and writes of that kind pulse addr_err one cycle after the grant.
//
// Configuration macro:
//   IMEM_ARB_ROUND_ROBIN_EN - when defined, conflicts in IDLE are resolved
//                             round-robin (loader wins the first conflict after
//                             reset). When undefined, fetch always wins.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   fetch_req/addr             CPU fetch request and byte address
//   fetch_gnt/rvalid/rdata     fetch grant, response valid, response data
//   load_req/we/lock/addr/wdata loader request, write flag, lock, address, data
//   load_gnt/rvalid/rdata      loader grant, response valid, response data
//   addr_err                   error pulse for the access granted last cycle
//   mem_en/we/index/wdata      memory strobe, write enable, word index, data
//   mem_rdata                  memory read data (one cycle after mem_en)
// ---------------------------------------------------------------------------
module imem_arbiter #(
    parameter int MEMORY_SIZE_WORDS = 1024,
    parameter int INDEX_WIDTH       = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fetch_req,
    input  logic [31:0]            fetch_addr,
    output logic                   fetch_gnt,
    output logic                   fetch_rvalid,
    output logic [31:0]            fetch_rdata,
    input  logic                   load_req,
    input  logic                   load_we,
    input  logic                   load_lock,
    input  logic [31:0]            load_addr,
    input  logic [31:0]            load_wdata,
    output logic                   load_gnt,
    output logic                   load_rvalid,
    output logic [31:0]            load_rdata,
    output logic                   addr_err,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [INDEX_WIDTH-1:0] mem_index,
    output logic [31:0]            mem_wdata,
    input  logic [31:0]            mem_rdata
);

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        fetch_rv_q;
    logic        load_rv_q;
    logic        nop_q;
    logic        aerr_q;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
    logic        last_load_q;
`endif

    logic        fetch_gnt_s;
    logic        load_gnt_s;
    logic        any_gnt_s;
    logic        write_s;
    logic        err_s;
    logic [31:0] sel_addr_s;

    // An address is bad if it is misaligned, if it has bits set above the index, or if its word index is past the memory end.
    function automatic logic addr_bad(input logic [31:0] addr);
        logic [31:0] word_idx;
        word_idx = addr >> 2;
        addr_bad = (addr[1:0] != 2'b00) ||
                   ((addr >> (INDEX_WIDTH + 2)) != 32'd0) ||
                   (word_idx >= 32'(MEMORY_SIZE_WORDS));
    endfunction

    // Arbitration: LOCKED serves only the loader; IDLE resolves conflicts.
    always_comb begin
        fetch_gnt_s = 1'b0;
        load_gnt_s  = 1'b0;
        if (reset) begin
            fetch_gnt_s = 1'b0;
            load_gnt_s  = 1'b0;
        end else if (state_q == ST_LOCKED) begin
            load_gnt_s = load_req;
        end else if (fetch_req && load_req) begin
`ifdef IMEM_ARB_ROUND_ROBIN_EN
            if (last_load_q) begin
                fetch_gnt_s = 1'b1;
            end else begin
                load_gnt_s = 1'b1;
            end
`else
            fetch_gnt_s = 1'b1;
`endif
        end else begin
            fetch_gnt_s = fetch_req;
            load_gnt_s  = load_req;
        end
    end

    // Memory-side request for the granted requester; bad accesses are not forwarded to memory.
    always_comb begin
        sel_addr_s = 32'h0;
        if (load_gnt_s) begin
            sel_addr_s = load_addr;
        end else if (fetch_gnt_s) begin
            sel_addr_s = fetch_addr;
        end else begin
            sel_addr_s = 32'h0;
        end
        any_gnt_s = fetch_gnt_s | load_gnt_s;
        write_s   = load_gnt_s & load_we;
        err_s     = any_gnt_s & addr_bad(sel_addr_s);
        mem_en    = any_gnt_s & ~err_s;
        mem_we    = write_s & ~err_s;
        mem_index = sel_addr_s[INDEX_WIDTH+1:2];
        if (mem_we) begin
            mem_wdata = load_wdata;
        end else begin
            mem_wdata = 32'h0;
        end
        fetch_gnt = fetch_gnt_s;
        load_gnt  = load_gnt_s;
    end

    // Lock FSM next state: enter on a locked loader grant, leave once lock drops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load_gnt_s && load_lock) begin
                    state_d = ST_LOCKED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (!load_lock) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, response pipeline and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fetch_rv_q <= 1'b0;
            load_rv_q  <= 1'b0;
            nop_q      <= 1'b0;
            aerr_q     <= 1'b0;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
            last_load_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_rv_q <= fetch_gnt_s;
            load_rv_q  <= load_gnt_s & ~load_we;
            nop_q      <= err_s & ~write_s;
            aerr_q     <= err_s;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
            // Only a real conflict in IDLE moves the pointer.
            if ((state_q == ST_IDLE) && fetch_req && load_req) begin
                last_load_q <= load_gnt_s;
            end else begin
                last_load_q <= last_load_q;
            end
`endif
        end
    end

    // Responses: a reset in the response cycle suppresses them; data is zero unless valid.
    always_comb begin
        fetch_rvalid = fetch_rv_q & ~reset;
        load_rvalid  = load_rv_q & ~reset;
        addr_err     = aerr_q & ~reset;
        if (!fetch_rvalid) begin
            fetch_rdata = 32'h0;
        end else if (nop_q) begin
            fetch_rdata = NOP_INSN;
        end else begin
            fetch_rdata = mem_rdata;
        end
        if (!load_rvalid) begin
            load_rdata = 32'h0;
        end else if (nop_q) begin
            load_rdata = NOP_INSN;
        end else begin
            load_rdata = mem_rdata;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_arbiter
//   Scoreboard bench for imem_arbiter with a 1024-word memory model.
//   Each cycle the bench drives requests and states which grant it expects.
//   It checks the combinational grant and the memory strobes.
//   It pushes the response it expects for the next cycle onto a queue.
//   The next cycle pops that entry and compares it with the DUT's response.
// ---------------------------------------------------------------------------
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req, load_req, load_we, load_lock;
    logic [31:0] fetch_addr, load_addr, load_wdata;
    logic        fetch_gnt, fetch_rvalid, load_gnt, load_rvalid, addr_err;
    logic [31:0] fetch_rdata, load_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_index;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];

    typedef struct {
        logic        fv;
        logic        lv;
        logic [31:0] d;
        logic        ae;
    } resp_t;
    resp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    imem_arbiter #(.MEMORY_SIZE_WORDS(1024), .INDEX_WIDTH(10)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .load_req(load_req), .load_we(load_we), .load_lock(load_lock),
        .load_addr(load_addr), .load_wdata(load_wdata), .load_gnt(load_gnt),
        .load_rvalid(load_rvalid), .load_rdata(load_rdata), .addr_err(addr_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_index(mem_index),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous memory model: read data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_index] <= mem_wdata;
            end
            mem_rdata <= mem[mem_index];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check the previous response and the current grant, then push the expected response.
    task automatic cyc(input logic fr, input logic [31:0] fa,
                       input logic lr, input logic lwe, input logic llk,
                       input logic [31:0] la, input logic [31:0] lwd,
                       input logic ef, input logic el);
        resp_t       r;
        logic [31:0] a;
        logic        err, go, wr;
        @(negedge clk);
        reset = 1'b0;
        fetch_req = fr; fetch_addr = fa;
        load_req = lr; load_we = lwe; load_lock = llk; load_addr = la; load_wdata = lwd;
        #1;
        if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
        end else begin
            r = '{fv: 1'b0, lv: 1'b0, d: 32'h0, ae: 1'b0};
        end
        check("fetch_rvalid", {31'h0, fetch_rvalid}, {31'h0, r.fv});
        check("fetch_rdata", fetch_rdata, r.fv ? r.d : 32'h0);
        check("load_rvalid", {31'h0, load_rvalid}, {31'h0, r.lv});
        check("load_rdata", load_rdata, r.lv ? r.d : 32'h0);
        check("addr_err", {31'h0, addr_err}, {31'h0, r.ae});
        check("fetch_gnt", {31'h0, fetch_gnt}, {31'h0, ef});
        check("load_gnt", {31'h0, load_gnt}, {31'h0, el});
        a   = el ? la : fa;
        go  = ef | el;
        wr  = el & lwe;
        err = go && ((a[1:0] != 2'b00) || (a[31:12] != 20'h0));
        check("mem_en", {31'h0, mem_en}, {31'h0, go & ~err});
        check("mem_we", {31'h0, mem_we}, {31'h0, wr & ~err});
        if (go) begin
            check("mem_index", {22'h0, mem_index}, {22'h0, a[11:2]});
        end
        if (wr && !err) begin
            check("mem_wdata", mem_wdata, lwd);
            ref_mem[a[11:2]] = lwd;
        end
        r.fv = ef;
        r.lv = el & ~lwe;
        r.d  = err ? 32'h0000_0013 : ref_mem[a[11:2]];
        r.ae = go & err;
        sb_q.push_back(r);
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    // Reset cycle with both requests active: every output must read zero, pending responses are dropped.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        fetch_req = 1'b1; fetch_addr = 32'h8;
        load_req = 1'b1; load_we = 1'b1; load_lock = 1'b0; load_addr = 32'h4; load_wdata = 32'h1;
        #1;
        check("rst fetch_gnt", {31'h0, fetch_gnt}, 32'h0);
        check("rst load_gnt", {31'h0, load_gnt}, 32'h0);
        check("rst fetch_rvalid", {31'h0, fetch_rvalid}, 32'h0);
        check("rst fetch_rdata", fetch_rdata, 32'h0);
        check("rst load_rvalid", {31'h0, load_rvalid}, 32'h0);
        check("rst load_rdata", load_rdata, 32'h0);
        check("rst addr_err", {31'h0, addr_err}, 32'h0);
        check("rst mem_en", {31'h0, mem_en}, 32'h0);
        check("rst mem_we", {31'h0, mem_we}, 32'h0);
        check("rst mem_index", {22'h0, mem_index}, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        sb_q.delete();
        sb_q.push_back('{fv: 1'b0, lv: 1'b0, d: 32'h0, ae: 1'b0});
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'hC0DE_0000 | 32'(i);
            ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        end
        reset = 1'b1;
        fetch_req = 1'b0; fetch_addr = 32'h0;
        load_req = 1'b0; load_we = 1'b0; load_lock = 1'b0; load_addr = 32'h0; load_wdata = 32'h0;
        do_reset();
        do_reset();

        // Fetch of 0x8 (index 2), then back-to-back fetches including the last word.
        cyc(1'b1, 32'h8,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'h4,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'hFFC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1);
        idle();

        // Four conflicting reads straight after reset.
        do_reset();
        for (int i = 0; i < 4; i++) begin
`ifdef IMEM_ARB_ROUND_ROBIN_EN
            cyc(1'b1, 32'h40 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 32'h80 + 32'(4 * i), 32'h0,
                (i % 2) == 1, (i % 2) == 0);
`else
            cyc(1'b1, 32'h40 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 32'h80 + 32'(4 * i), 32'h0,
                1'b1, 1'b0);
`endif
        end
        idle();

        // Locked write of 0xDEADBEEF to 0x10; fetch is held off until unlock.
        cyc(1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1);
        cyc(1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0, 1'b1);
        cyc(1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();

        // Erroneous accesses: misaligned fetch, out-of-range fetch, bad write, bad loader read.
        cyc(1'b1, 32'h1002, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h5, 32'h1234_5678, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h3001, 32'h0, 1'b0, 1'b1);
        idle();

        // Reset in the response cycle of a read suppresses that response.
        cyc(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        do_reset();
        cyc(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();

        // Reset leaves LOCKED: fetch is granted immediately afterwards.
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h14, 32'h5555_AAAA, 1'b0, 1'b1);
        do_reset();
        cyc(1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter MEMORY_SIZE_WORDS, default 1024, giving the number of 32-bit words behind the arbiter.
REQ-002 SHALL have parameter INDEX_WIDTH, default 10, giving the width of the word index (log2 of MEMORY_SIZE_WORDS).
REQ-003 SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: the single clock; all logic is rising-edge.
- reset, in, 1: synchronous, active-high reset.
- fetch_req, in, 1: CPU fetch request.
- fetch_addr, in, 32: fetch byte address.
- fetch_gnt, out, 1: fetch accepted this cycle.
- fetch_rvalid, out, 1: fetch_rdata is valid.
- fetch_rdata, out, 32: fetched instruction.
- load_req, in, 1: loader request.
- load_we, in, 1: loader write (1) or read (0).
- load_lock, in, 1: loader requests exclusive ownership.
- load_addr, in, 32: loader byte address.
- load_wdata, in, 32: loader write data.
- load_gnt, out, 1: loader access accepted this cycle.
- load_rvalid, out, 1: load_rdata is valid.
- load_rdata, out, 32: loader read data.
- addr_err, out, 1: the granted access was out of range or misaligned.
- mem_en, out, 1: memory access strobe.
- mem_we, out, 1: memory write enable.
- mem_index, out, INDEX_WIDTH: memory word index.
- mem_wdata, out, 32: memory write data.
- mem_rdata, in, 32: memory read data, valid one cycle after mem_en.

Function
REQ-004 SHALL drive mem_index from address bits [INDEX_WIDTH+1:2] of the granted requester.
REQ-005 SHALL issue at most one grant per cycle; the grant and mem_en/mem_we/mem_index/mem_wdata SHALL be combinational in the same cycle.
REQ-006 SHALL give read latency 1: a grant in cycle N SHALL produce rvalid plus rdata equal to mem_rdata in cycle N+1, to the same requester, for one cycle.
REQ-007 SHALL support back-to-back grants every cycle with no bubble.
REQ-008 SHALL treat a granted loader write (load_we=1) as mem_we=1, with no load_rvalid response.
REQ-009 SHALL use a two-state FSM:
- IDLE: arbitrate normally.
- LOCKED: grant only the loader.
- IDLE→LOCKED: on a loader grant while load_lock=1.
- LOCKED→IDLE: in the first cycle with load_lock=0.
REQ-010 SHALL hold fetch_gnt=0 in LOCKED even when fetch_req=1; fetch SHALL NOT be dropped and SHALL be served after unlock.
REQ-011 SHALL treat an access as erroneous when addr[1:0]≠0 or addr[31:INDEX_WIDTH+2]≠0; such an access SHALL still be granted.
REQ-012 For an erroneous access, SHALL hold mem_en=0 and mem_we=0, and in cycle N+1 SHALL assert rvalid for a read with rdata=0x00000013 (NOP) together with addr_err=1 for one cycle.
REQ-013 SHALL pulse addr_err=1 in cycle N+1 for an erroneous write, with no rvalid.
REQ-014 SHALL keep rdata outputs at 0 whenever the corresponding rvalid=0.

Reset
REQ-015 While reset=1:
- all outputs SHALL be 0.
- the FSM SHALL be IDLE.
- any pending rvalid SHALL be discarded.
- the round-robin pointer SHALL point to fetch-last, so the loader wins the first conflict.
REQ-016 A reset asserted in cycle N+1 of an in-flight read SHALL suppress that rvalid.

Configuration
REQ-017 Macro IMEM_ARB_ROUND_ROBIN_EN:
- Defined: on simultaneous fetch_req and load_req in IDLE, the requester not granted most recently SHALL win; the pointer updates only on conflicting grants.
- Undefined: fetch SHALL always win conflicts in IDLE.

Verification
REQ-018 Fetch only: fetch_req=1, fetch_addr=0x8 → mem_index=2 the same cycle; next cycle fetch_rvalid=1 and fetch_rdata equals mem_rdata.
REQ-019 Conflict with IMEM_ARB_ROUND_ROBIN_EN, both requesting reads for 4 cycles after reset → grant order load, fetch, load, fetch. Without the macro → fetch granted all 4 cycles.
REQ-020 Lock: load_lock=1, then loader writes 0xDEADBEEF to 0x10 while fetch_req=1 → fetch_gnt=0 during lock. After load_lock=0, a fetch of 0x10 returns 0xDEADBEEF.
REQ-021 Error: fetch_addr=0x1002 → mem_en=0; next cycle fetch_rvalid=1, fetch_rdata=0x00000013, addr_err=1.
REQ-022 Reset mid-read: grant in cycle N, reset=1 in cycle N+1 → fetch_rvalid=0, all outputs 0, FSM IDLE.
